// File: rtl/fact_cu.sv
// Control unit for an iterative factorial datapath: sequences an external
// down counter and product register, one multiply per CHECK/MULT pair.
module fact_cu #(
  parameter int MAX_N = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [3:0] n,
  input  logic [3:0] cnt_q,
  output logic       ld_count,
  output logic       cnt_en,
  output logic       ld_reg,
  output logic       sel,
  output logic       oe,
  output logic       done,
  output logic       err,
  output logic       busy,
  output logic [2:0] cs
);

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_LOAD  = 3'b001;
  localparam logic [2:0] S_CHECK = 3'b010;
  localparam logic [2:0] S_MULT  = 3'b011;
  localparam logic [2:0] S_DONE  = 3'b100;
  localparam logic [2:0] S_ERR   = 3'b101;

  localparam logic [3:0] MAX_N_L = 4'(MAX_N);

  logic [2:0] state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // go and n only matter in IDLE; DONE/ERR wait for go to fall so a held
  // request cannot restart the computation.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (go) state_d = (n > MAX_N_L) ? S_ERR : S_LOAD;
        else    state_d = S_IDLE;
      end
      S_LOAD:  state_d = S_CHECK;
      S_CHECK: state_d = (cnt_q > 4'd1) ? S_MULT : S_DONE;
      S_MULT:  state_d = S_CHECK;
      S_DONE:  state_d = go ? S_DONE : S_IDLE;
      S_ERR:   state_d = go ? S_ERR  : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore decode: outputs depend on state_q alone.
  always_comb begin
    ld_count = 1'b0;
    cnt_en   = 1'b0;
    ld_reg   = 1'b0;
    sel      = 1'b0;
    oe       = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_LOAD: begin
        ld_count = 1'b1;
        ld_reg   = 1'b1;
        busy     = 1'b1;
      end
      S_CHECK: busy = 1'b1;
      S_MULT: begin
        ld_reg = 1'b1;
        sel    = 1'b1;
        cnt_en = 1'b1;
        busy   = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        oe   = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  assign cs = state_q;

endmodule

// File: tb/tb_fact_cu.sv
// Bench for fact_cu: models the counter/product datapath and checks latency,
// pulse counts and results against a queue of expected outcomes.
module tb_fact_cu;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic [3:0] n_r;
  logic [3:0] cnt;
  logic       ld_count, cnt_en, ld_reg, sel, oe, done, err, busy;
  logic [2:0] cs;

  logic [31:0] prod;
  int n_ldcnt = 0, n_ldreg = 0, n_cnten = 0, n_ovl = 0;
  int total = 0, bad = 0;

  typedef struct {
    int          edge_n;
    logic        is_err;
    logic [31:0] prod;
    int          ldreg;
    int          cnten;
  } exp_t;
  exp_t sb[$];

  fact_cu #(.MAX_N(12)) dut (
    .clk(clk), .rst(rst), .go(go), .n(n_r), .cnt_q(cnt),
    .ld_count(ld_count), .cnt_en(cnt_en), .ld_reg(ld_reg), .sel(sel),
    .oe(oe), .done(done), .err(err), .busy(busy), .cs(cs)
  );

  always #5 clk = ~clk;

  // Downstream datapath plus pulse counters.
  always @(posedge clk) begin
    if (ld_count)    cnt <= n_r;
    else if (cnt_en) cnt <= cnt - 4'd1;
    if (ld_reg)      prod <= sel ? 32'(prod * {28'd0, cnt}) : 32'd1;
    if (ld_count) n_ldcnt <= n_ldcnt + 1;
    if (ld_reg)   n_ldreg <= n_ldreg + 1;
    if (cnt_en)   n_cnten <= n_cnten + 1;
    if (ld_count && cnt_en) n_ovl <= n_ovl + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fact(input int k);
    logic [31:0] f = 32'd1;
    for (int i = 2; i <= k; i++) f = f * 32'(i);
    return f;
  endfunction

  function automatic logic [7:0] outs();
    return {ld_count, cnt_en, ld_reg, sel, oe, done, err, busy};
  endfunction

  // Start an operation, wait for done/err, compare against the scoreboard,
  // optionally hold go, then release and check the return to IDLE.
  task automatic op(input int n, input bit drop_in_check, input int hold);
    exp_t e, g;
    int b_ldcnt, b_ldreg, b_cnten, k;
    bit seen;
    @(negedge clk);
    n_r = 4'(n);
    go  = 1'b1;
    b_ldcnt = n_ldcnt; b_ldreg = n_ldreg; b_cnten = n_cnten;
    e.is_err = (n > 12);
    e.edge_n = e.is_err ? 1 : (n <= 1 ? 3 : 2 * n + 1);
    e.prod   = fact(n);
    e.ldreg  = (n > 1 ? n - 1 : 0) + 1;
    e.cnten  = (n > 1 ? n - 1 : 0);
    sb.push_back(e);
    seen = 0;
    for (k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (drop_in_check && cs == 3'b010) go = 1'b0;
      if (done || err) begin seen = 1; break; end
    end
    g = sb.pop_front();
    if (!seen) begin
      chk("timeout", 32'd0, 32'd1);
      go = 1'b0;
      return;
    end
    chk($sformatf("edge n=%0d", n), 32'(k), 32'(g.edge_n));
    chk($sformatf("err n=%0d", n), {31'd0, err}, {31'd0, g.is_err});
    chk($sformatf("done n=%0d", n), {31'd0, done & oe}, {31'd0, ~g.is_err});
    if (g.is_err) begin
      chk($sformatf("ldcnt n=%0d", n), 32'(n_ldcnt - b_ldcnt), 32'd0);
    end else begin
      chk($sformatf("prod n=%0d", n), prod, g.prod);
      chk($sformatf("ldcnt n=%0d", n), 32'(n_ldcnt - b_ldcnt), 32'd1);
      chk($sformatf("ldreg n=%0d", n), 32'(n_ldreg - b_ldreg), 32'(g.ldreg));
      chk($sformatf("cnten n=%0d", n), 32'(n_cnten - b_cnten), 32'(g.cnten));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold n=%0d", n), {29'd0, cs}, g.is_err ? 32'd5 : 32'd4);
    end
    @(negedge clk);
    go = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("idle cs n=%0d", n), {29'd0, cs}, 32'd0);
    chk($sformatf("idle outs n=%0d", n), {24'd0, outs()}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; go = 1'b1; n_r = 4'd5;
    #1;
    chk("rst cs", {29'd0, cs}, 32'd0);
    chk("rst outs", {24'd0, outs()}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst hold cs", {29'd0, cs}, 32'd0);
    @(negedge clk);
    rst = 1'b0; go = 1'b0;

    op(5, 0, 10);
    op(0, 0, 0);
    op(1, 0, 2);
    op(12, 0, 1);
    op(13, 0, 3);
    op(4, 1, 0);
    op(2, 0, 0);

    // Reset in the middle of a computation.
    @(negedge clk);
    n_r = 4'd7; go = 1'b1;
    for (int k = 0; k < 20 && cs != 3'b011; k++) begin
      @(posedge clk); #1;
    end
    chk("reach mult", {29'd0, cs}, 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("async rst cs", {29'd0, cs}, 32'd0);
    chk("async rst outs", {24'd0, outs()}, 32'd0);
    @(posedge clk); #1;
    chk("rst held cs", {29'd0, cs}, 32'd0);
    @(negedge clk);
    rst = 1'b0; go = 1'b0;
    op(3, 0, 0);

    chk("overlap", 32'(n_ovl), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
